serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor that computes diff = A - B - Bin on WIDTH-bit operands.
- Processes DIGIT bits per clock, least-significant digit first, and chains the borrow through a register between digits.
- Operands enter on a valid/ready handshake; the result leaves on a second valid/ready handshake.
- Successor to the 4-bit combinational ripple subtractor: adds arbitrary width, an area/latency trade-off through DIGIT, backpressure, and signed-overflow and zero flags.

Parameters:
WIDTH  16  operand and result width in bits; must be a multiple of DIGIT
DIGIT  4   bits processed per clock; must satisfy 1 <= DIGIT <= WIDTH
NDIG   WIDTH/DIGIT  derived localparam, not overridable; number of RUN cycles

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      operand request
in_ready   output  1      block can accept operands
A          input   WIDTH  minuend
B          input   WIDTH  subtrahend
Bin        input   1      borrow-in
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
diff       output  WIDTH  A - B - Bin, modulo 2^WIDTH
Bout       output  1      borrow-out from the MSB; 1 when A < B + Bin unsigned
ovf        output  1      signed (two's complement) overflow
zero       output  1      diff == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
  - Asserting rst_n forces IDLE immediately, regardless of the clock.
  - Reset values: in_ready=1 (combinational from IDLE), out_valid=0, diff=0, Bout=0, ovf=0, zero=0.
  - The operand registers, the borrow register and the digit index all clear to 0.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready=1. On in_valid && in_ready at a rising edge:
    - capture A, B and Bin;
    - set borrow := Bin and idx := 0;
    - go to RUN.
  - RUN: in_ready=0 and out_valid=0. On each clock:
    - slice [idx*DIGIT +: DIGIT] := digit difference;
    - borrow := digit borrow-out;
    - idx++.
    - On the cycle where idx == NDIG-1, also register:
      - Bout := final borrow-out;
      - ovf := borrow into the MSB XOR borrow out of the MSB;
      - zero := (complete result == 0).
    - After that cycle, go to DONE.
  - DONE: out_valid=1 and in_ready=0.
    - diff, Bout, ovf and zero are held stable until the handshake.
    - On out_ready, go to IDLE. out_valid drops the next cycle and in_ready rises the next cycle.
    - No new operand is accepted in the same cycle as the result handshake.
- Latency:
  - out_valid rises NDIG clocks after the accepting edge.
  - Throughput is one operation per NDIG+2 cycles when out_ready=1.
- Digit arithmetic is per bit: d = a^b^bi and bo = (~a&b) | (~a&bi) | (b&bi), rippled LSB to MSB inside the digit.
- Outputs outside DONE:
  - diff, Bout, ovf and zero are meaningful only while out_valid=1.
  - During RUN, diff shows partially written slices with the remaining slices unchanged.
  - Consumers must qualify these outputs with out_valid.
- Input stability: A, B and Bin are sampled only on the accepting edge. Changes during RUN or DONE have no effect.
- in_valid is ignored in RUN and DONE. A producer holding in_valid is accepted on the first IDLE cycle.
- DIGIT == WIDTH is legal: a single RUN cycle, so out_valid rises 1 clock after acceptance.
- If WIDTH % DIGIT != 0 or DIGIT < 1, elaboration fails.
- Reset during RUN or DONE aborts the operation. No out_valid pulse is produced for the aborted operation.

Decomposition:
- Package sub_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the idx width function, clog2(NDIG) with a minimum of 1.
- One sub-module, digit_subtractor #(DIGIT). It is purely combinational:
  - inputs: a[DIGIT], b[DIGIT], bi;
  - outputs: d[DIGIT], bo, b_msb (the borrow into its top bit, used for ovf).
- The top level owns the FSM, the operand, result, borrow and index registers, and the flag logic.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- 0x0005 - 0x0003, Bin=0: diff=0x0002, Bout=0, ovf=0, zero=0. out_valid rises exactly 4 clocks after acceptance.
- 0x0000 - 0x0001, Bin=0: diff=0xFFFF, Bout=1, ovf=0.
  - Repeat with 0x0000 - 0x0000, Bin=1: diff=0xFFFF, Bout=1.
- 0x8000 - 0x0001, Bin=0: diff=0x7FFF, Bout=0, ovf=1.
  - Repeat with 0x7FFF - 0xFFFF: diff=0x8000, Bout=1, ovf=1.
- 0x1234 - 0x1233, Bin=1: diff=0x0000, zero=1, Bout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid and operands.
  - out_valid stays at 1 and diff stays constant.
  - in_ready stays at 0 and nothing is accepted.
  - After out_ready=1: in_ready=1 on the next cycle, and the queued in_valid is accepted the cycle after that.
- Reset and degenerate width:
  - Pull rst_n low mid-RUN (idx=2), asynchronously between edges. Outputs go to their reset values immediately, with no out_valid pulse. After release, 0x00FF - 0x000F gives diff=0x00F0.
  - With DIGIT=16, 0xABCD - 0x0BCD gives diff=0xA000 with 1-clock latency.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// the sizing helper for the digit index register.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit configuration still needs a one-bit index register.
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit ripple subtractor slice; also exposes the borrow into
// its top bit so the caller can form the signed-overflow flag.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             b_msb
);

    logic [DIGIT:0] chain;

    assign chain[0] = bi;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign d[i]       = a[i] ^ b[i] ^ chain[i];
        assign chain[i+1] = (~a[i] & b[i]) | (~a[i] & chain[i]) | (b[i] & chain[i]);
    end

    assign bo    = chain[DIGIT];
    assign b_msb = chain[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor computing A - B - Bin one DIGIT-bit slice per clock,
// LSB slice first, with valid/ready handshakes on operands and result.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int IW   = idx_width(NDIG);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] diff_next;
    logic             borrow;
    logic [IW-1:0]    idx;
    logic             bout_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_dig;
    logic             bo_dig;
    logic             bmsb_dig;
    logic             last_dig;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                a_dig = a_reg[i*DIGIT +: DIGIT];
                b_dig = b_reg[i*DIGIT +: DIGIT];
            end
        end
    end

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .a     (a_dig),
        .b     (b_dig),
        .bi    (borrow),
        .d     (d_dig),
        .bo    (bo_dig),
        .b_msb (bmsb_dig)
    );

    // Result as it will look once the current slice is written; on the last
    // digit this is the complete difference used for the zero flag.
    always_comb begin
        diff_next = diff_reg;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                diff_next[i*DIGIT +: DIGIT] = d_dig;
            end
        end
    end

    assign last_dig = (idx == IW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last_dig)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Flags are registered only on the final digit so they stay stable in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            borrow   <= 1'b0;
            idx      <= '0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        borrow <= Bin;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    diff_reg <= diff_next;
                    borrow   <= bo_dig;
                    idx      <= idx + IW'(1);
                    if (last_dig) begin
                        bout_reg <= bo_dig;
                        ovf_reg  <= bmsb_dig ^ bo_dig;
                        zero_reg <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_reg;
    assign Bout      = bout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, random
// operands against an arithmetic model, backpressure, reset abort, DIGIT=WIDTH.
module tb_serial_subtractor;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        Bout;
    logic        ovf;
    logic        zero;

    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] diff2;
    logic        Bout2;
    logic        ovf2;
    logic        zero2;

    int tests_run;
    int tests_failed;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .Bout      (Bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .diff      (diff2),
        .Bout      (Bout2),
        .ovf       (ovf2),
        .zero      (zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic vec_t refModel(input logic [15:0] a, input logic [15:0] b, input logic bin);
        vec_t r;
        int   ud;
        int   sd;
        ud = int'(a) - int'(b) - int'(bin);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r.a    = a;
        r.b    = b;
        r.bin  = bin;
        r.bout = (ud < 0);
        if (ud < 0) ud += 65536;
        r.diff = ud[15:0];
        r.ovf  = (sd < -32768) || (sd > 32767);
        r.zero = (r.diff == 16'h0000);
        return r;
    endfunction

    // Presents operands, waits for acceptance and result; returns clocks from accept to out_valid.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin, output int lat);
        int waitCnt;
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = 1'b1;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) checkVal("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) checkVal("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic checkOutput(input string name, input vec_t exp);
        checkVal({name, "_valid"}, 32'(out_valid), 32'd1);
        checkVal({name, "_diff"},  32'(diff),      32'(exp.diff));
        checkVal({name, "_bout"},  32'(Bout),      32'(exp.bout));
        checkVal({name, "_ovf"},   32'(ovf),       32'(exp.ovf));
        checkVal({name, "_zero"},  32'(zero),      32'(exp.zero));
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        table_v [7];
        vec_t        exp;
        int          lat;
        logic [15:0] held;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_valid2    = 1'b0;
        out_ready    = 1'b0;
        out_ready2   = 1'b0;
        A            = '0;
        B            = '0;
        Bin          = 1'b0;

        table_v[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        table_v[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        table_v[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        table_v[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        table_v[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        table_v[5] = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        table_v[6] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        #12;
        checkVal("reset_in_ready",  32'(in_ready),   32'd1);
        checkVal("reset_out_valid", 32'(out_valid),  32'd0);
        checkVal("reset_diff",      32'(diff),       32'd0);
        checkVal("reset_flags",     {29'd0, Bout, ovf, zero}, 32'd0);
        checkVal("reset_out_valid2", 32'(out_valid2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(table_v[i].a, table_v[i].b, table_v[i].bin, lat);
            checkOutput($sformatf("vec%0d", i), table_v[i]);
            checkVal($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            releaseResult();
        end

        for (int i = 0; i < 40; i++) begin
            exp = refModel(16'($urandom), 16'($urandom), 1'($urandom));
            applyStimulus(exp.a, exp.b, exp.bin, lat);
            checkOutput($sformatf("rand%0d", i), exp);
            releaseResult();
        end

        // Backpressure: result must hold and no operand may be taken while DONE.
        applyStimulus(16'h4321, 16'h1111, 1'b0, lat);
        held = diff;
        checkVal("bp_diff", 32'(held), 32'h3210);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            A        = 16'($urandom);
            B        = 16'($urandom);
            @(negedge clk);
            checkVal($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            checkVal($sformatf("bp_hold_diff%0d", i),  32'(diff),      32'(held));
            checkVal($sformatf("bp_hold_ready%0d", i), 32'(in_ready),  32'd0);
        end
        A         = 16'h0010;
        B         = 16'h0001;
        Bin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkVal("bp_release_in_ready",  32'(in_ready),  32'd1);
        checkVal("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkVal("bp_queued_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkVal("bp_queued_latency", 32'(lat),  32'd4);
        checkVal("bp_queued_diff",    32'(diff), 32'h000F);
        releaseResult();

        // Asynchronous reset in the middle of RUN aborts the operation.
        A        = 16'h1111;
        B        = 16'h0001;
        Bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("abort_in_ready",  32'(in_ready),  32'd1);
        checkVal("abort_out_valid", 32'(out_valid), 32'd0);
        checkVal("abort_diff",      32'(diff),      32'd0);
        checkVal("abort_flags",     {29'd0, Bout, ovf, zero}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkVal($sformatf("abort_no_pulse%0d", i), 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h00FF, 16'h000F, 1'b0, lat);
        checkOutput("after_abort", '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0});
        checkVal("after_abort_latency", 32'(lat), 32'd4);
        releaseResult();

        // Single-digit instance: one RUN cycle.
        A         = 16'hABCD;
        B         = 16'h0BCD;
        Bin       = 1'b0;
        checkVal("d16_in_ready", 32'(in_ready2), 32'd1);
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        checkVal("d16_not_yet_valid", 32'(out_valid2), 32'd0);
        @(negedge clk);
        checkVal("d16_valid_1clk", 32'(out_valid2), 32'd1);
        checkVal("d16_diff",       32'(diff2),      32'hA000);
        checkVal("d16_bout",       32'(Bout2),      32'd0);
        checkVal("d16_ovf",        32'(ovf2),       32'd0);
        checkVal("d16_zero",       32'(zero2),      32'd0);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        checkVal("d16_release", 32'(in_ready2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
